// File: rtl/fu_pkg.sv
// Shared definitions for the functional-unit slice: limb width and the
// sequencer state encoding.
package fu_pkg;

    localparam int LW = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/adder_seq_ctrl_adder.sv
// Purely combinational 32-bit limb adder with carry, signed overflow and
// propagate/generate vectors.
module adder
    import fu_pkg::*;
(
    input  logic [LW-1:0] a,
    input  logic [LW-1:0] b,
    input  logic          cin,
    output logic [LW-1:0] s,
    output logic          cout,
    output logic          ovf,
    output logic [LW-1:0] p,
    output logic [LW-1:0] g
);

    logic [LW:0] full_s;

    assign full_s = {1'b0, a} + {1'b0, b} + {{LW{1'b0}}, cin};
    assign s      = full_s[LW-1:0];
    assign cout   = full_s[LW];
    // Overflow only means something on the top limb; the sequencer samples it there.
    assign ovf    = (a[LW-1] == b[LW-1]) && (s[LW-1] != a[LW-1]);
    assign p      = a ^ b;
    assign g      = a & b;

endmodule

// File: rtl/adder_seq_ctrl.sv
// Multi-precision add/subtract sequencer: streams WORDS limbs LSB-first through
// one shared adder, chaining the carry, and hands the result out on valid/ready.
module adder_seq_ctrl
    import fu_pkg::*;
#(
    parameter int WORDS = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [WORDS*LW-1:0] req_a,
    input  logic [WORDS*LW-1:0] req_b,
    input  logic                req_sub,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [WORDS*LW-1:0] rsp_sum,
    output logic                rsp_cout,
    output logic                rsp_ovf,
    output logic                busy
);

    localparam int              IDXW     = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int              TW       = WORDS * LW;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(WORDS - 1);
    localparam logic [IDXW-1:0] IDX_ONE  = IDXW'(1);

    state_t          state_r;
    logic [IDXW-1:0] idx_r;
    logic            carry_r;
    logic [TW-1:0]   a_r;
    logic [TW-1:0]   b_r;
    logic [TW-1:0]   sum_r;
    logic            rsp_cout_r;
    logic            rsp_ovf_r;
    logic            req_ready_r;
    logic            rsp_valid_r;
    logic            busy_r;

    logic [LW-1:0]   limb_a_s;
    logic [LW-1:0]   limb_b_s;
    logic            limb_cin_s;
    logic [LW-1:0]   limb_sum_s;
    logic            limb_cout_s;
    logic            limb_ovf_s;

    // Adder operand mux: the current limb while running, quiet zeros otherwise.
    always_comb begin
        limb_a_s   = {LW{1'b0}};
        limb_b_s   = {LW{1'b0}};
        limb_cin_s = 1'b0;
        if (state_r == RUN) begin
            limb_a_s   = a_r[int'(idx_r)*LW +: LW];
            limb_b_s   = b_r[int'(idx_r)*LW +: LW];
            limb_cin_s = carry_r;
        end else begin
            limb_a_s   = {LW{1'b0}};
            limb_b_s   = {LW{1'b0}};
            limb_cin_s = 1'b0;
        end
    end

    adder u_adder (
        .a    (limb_a_s),
        .b    (limb_b_s),
        .cin  (limb_cin_s),
        .s    (limb_sum_s),
        .cout (limb_cout_s),
        .ovf  (limb_ovf_s),
        .p    (),
        .g    ()
    );

    // Sequencer FSM with all handshake and result outputs registered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= IDLE;
            idx_r       <= {IDXW{1'b0}};
            carry_r     <= 1'b0;
            a_r         <= {TW{1'b0}};
            b_r         <= {TW{1'b0}};
            sum_r       <= {TW{1'b0}};
            rsp_cout_r  <= 1'b0;
            rsp_ovf_r   <= 1'b0;
            req_ready_r <= 1'b0;
            rsp_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    req_ready_r <= 1'b1;
                    if (req_valid && req_ready_r) begin
                        // Subtraction is A + ~B + 1, so fold the inversion in at capture.
                        a_r         <= req_a;
                        b_r         <= req_sub ? ~req_b : req_b;
                        carry_r     <= req_sub;
                        idx_r       <= {IDXW{1'b0}};
                        req_ready_r <= 1'b0;
                        busy_r      <= 1'b1;
                        state_r     <= RUN;
                    end
                end
                RUN: begin
                    sum_r[int'(idx_r)*LW +: LW] <= limb_sum_s;
                    carry_r <= limb_cout_s;
                    if (idx_r == LAST_IDX) begin
                        rsp_cout_r  <= limb_cout_s;
                        rsp_ovf_r   <= limb_ovf_s;
                        rsp_valid_r <= 1'b1;
                        idx_r       <= {IDXW{1'b0}};
                        state_r     <= DONE;
                    end else begin
                        idx_r <= idx_r + IDX_ONE;
                    end
                end
                DONE: begin
                    if (rsp_ready) begin
                        rsp_valid_r <= 1'b0;
                        req_ready_r <= 1'b1;
                        busy_r      <= 1'b0;
                        state_r     <= IDLE;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    rsp_valid_r <= 1'b0;
                    req_ready_r <= 1'b0;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready = req_ready_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_sum   = sum_r;
    assign rsp_cout  = rsp_cout_r;
    assign rsp_ovf   = rsp_ovf_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_adder_seq_ctrl.sv
// Scoreboarded directed and random checks of adder_seq_ctrl at WORDS=4 and WORDS=1.
module tb_adder_seq_ctrl;

    typedef struct {
        logic [127:0] sum;
        logic         cout;
        logic         ovf;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset;

    logic         rv4, rr4, sub4, vv4, rdy4, cout4, ovf4, busy4;
    logic [127:0] a4, b4, sum4;
    logic         rv1, rr1, sub1, vv1, rdy1, cout1, ovf1, busy1;
    logic [31:0]  a1, b1, sum1;

    exp_t q4[$];
    exp_t q1[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    adder_seq_ctrl #(.WORDS(4)) u_dut4 (
        .clk(clk), .reset(reset),
        .req_valid(rv4), .req_ready(rr4), .req_a(a4), .req_b(b4), .req_sub(sub4),
        .rsp_valid(vv4), .rsp_ready(rdy4), .rsp_sum(sum4), .rsp_cout(cout4),
        .rsp_ovf(ovf4), .busy(busy4)
    );

    adder_seq_ctrl #(.WORDS(1)) u_dut1 (
        .clk(clk), .reset(reset),
        .req_valid(rv1), .req_ready(rr1), .req_a(a1), .req_b(b1), .req_sub(sub1),
        .rsp_valid(vv1), .rsp_ready(rdy1), .rsp_sum(sum1), .rsp_cout(cout1),
        .rsp_ovf(ovf1), .busy(busy1)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Behavioural full-width A+B / A-B reference; sel=1 selects the 32-bit DUT.
    function automatic exp_t model(input bit sel, input logic [127:0] a_in,
                                   input logic [127:0] b_in, input bit sub);
        exp_t         e;
        int           w;
        logic [127:0] mask;
        logic [127:0] a;
        logic [127:0] b;
        logic [128:0] full;
        bit           sa, sb, ss;
        w    = sel ? 32 : 128;
        mask = sel ? {96'd0, {32{1'b1}}} : {128{1'b1}};
        a    = a_in & mask;
        b    = b_in & mask;
        if (sub) begin
            full   = {1'b0, a} - {1'b0, b};
            e.cout = (a >= b);
        end else begin
            full   = {1'b0, a} + {1'b0, b};
            e.cout = sel ? full[32] : full[128];
        end
        e.sum = full[127:0] & mask;
        sa    = a[w-1];
        sb    = b[w-1];
        ss    = e.sum[w-1];
        e.ovf = sub ? ((sa != sb) && (ss != sa)) : ((sa == sb) && (ss != sa));
        return e;
    endfunction

    // Enters and leaves on a falling edge; the request is accepted on the edge in between.
    task automatic send(input bit sel, input logic [127:0] a, input logic [127:0] b, input bit sub);
        int n;
        if (sel) begin
            a1 = a[31:0]; b1 = b[31:0]; sub1 = sub; rv1 = 1'b1;
        end else begin
            a4 = a; b4 = b; sub4 = sub; rv4 = 1'b1;
        end
        n = 0;
        while (((sel ? rr1 : rr4) !== 1'b1) && (n < 50)) begin
            @(negedge clk);
            n++;
        end
        check("accept_wait", (n < 50), 1'b1);
        @(posedge clk);
        if (sel) q1.push_back(model(sel, a, b, sub));
        else     q4.push_back(model(sel, a, b, sub));
        @(negedge clk);
        if (sel) rv1 = 1'b0;
        else     rv4 = 1'b0;
    endtask

    // Waits for the response, consumes it (optionally with random back-pressure)
    // and checks it against the scoreboard. lat counts edges from the accept edge.
    task automatic recv(input bit sel, input bit rnd, output int lat);
        exp_t e;
        bit   r;
        bit   seen;
        bit   done;
        seen = 1'b0;
        done = 1'b0;
        lat  = 1;
        for (int n = 0; (n < 200) && !done; n++) begin
            if ((sel ? vv1 : vv4) === 1'b1) begin
                seen = 1'b1;
                r    = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
                if (sel) rdy1 = r;
                else     rdy4 = r;
                if (r) begin
                    check("sb_nonempty", ((sel ? q1.size() : q4.size()) != 0), 1'b1);
                    if (sel) e = q1.pop_front();
                    else     e = q4.pop_front();
                    check(sel ? "sum_w1" : "sum_w4", sel ? {96'd0, sum1} : sum4, e.sum);
                    check(sel ? "cout_w1" : "cout_w4", sel ? cout1 : cout4, e.cout);
                    check(sel ? "ovf_w1" : "ovf_w4", sel ? ovf1 : ovf4, e.ovf);
                    done = 1'b1;
                end
            end
            @(posedge clk);
            @(negedge clk);
            if (!seen) lat++;
        end
        check("rsp_wait", done, 1'b1);
        rdy1 = 1'b0;
        rdy4 = 1'b0;
    endtask

    initial begin
        int           lat;
        bit           saw_valid;
        logic [127:0] hold_sum;
        logic         hold_cout, hold_ovf;
        exp_t         e;
        bit           sel;
        logic [127:0] ra, rb;

        reset = 1'b1;
        rv4 = 1'b0; sub4 = 1'b0; rdy4 = 1'b0; a4 = 128'd0; b4 = 128'd0;
        rv1 = 1'b0; sub1 = 1'b0; rdy1 = 1'b0; a1 = 32'd0;  b1 = 32'd0;
        repeat (2) @(negedge clk);
        check("rst_req_ready", rr4, 1'b0);
        check("rst_rsp_valid", vv4, 1'b0);
        check("rst_sum", sum4, 128'd0);
        check("rst_cout_ovf", {cout4, ovf4}, 2'b00);
        check("rst_busy", busy4, 1'b0);
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("ready_after_rst_w4", rr4, 1'b1);
        check("ready_after_rst_w1", rr1, 1'b1);

        // All-ones + 1 wraps to zero with carry; latency counted from the accept edge.
        send(1'b0, {128{1'b1}}, 128'd1, 1'b0);
        check("busy_run", busy4, 1'b1);
        check("ready_run", rr4, 1'b0);
        recv(1'b0, 1'b0, lat);
        check("latency_w4", lat, 5);
        send(1'b1, {128{1'b1}}, 128'd1, 1'b0);
        recv(1'b1, 1'b0, lat);
        check("latency_w1", lat, 2);

        // 0 - 1 borrows out of the top limb.
        send(1'b0, 128'd0, 128'd1, 1'b1);
        recv(1'b0, 1'b0, lat);

        // Signed overflow in both directions.
        send(1'b0, {1'b0, {127{1'b1}}}, 128'd1, 1'b0);
        recv(1'b0, 1'b0, lat);
        send(1'b0, {1'b1, 127'd0}, 128'd1, 1'b1);
        recv(1'b0, 1'b0, lat);

        // Back-pressure in DONE: outputs frozen, new requests refused.
        send(1'b0, 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210, 128'h1111_2222_3333_4444_5555_6666_7777_8888, 1'b0);
        for (int n = 0; (n < 20) && (vv4 !== 1'b1); n++) @(negedge clk);
        check("done_reached", vv4, 1'b1);
        hold_sum = sum4; hold_cout = cout4; hold_ovf = ovf4;
        a4 = 128'hdead_beef; b4 = 128'd5; rv4 = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            @(negedge clk);
            check("hold_valid", vv4, 1'b1);
            check("hold_sum", sum4, hold_sum);
            check("hold_flags", {cout4, ovf4}, {hold_cout, hold_ovf});
            check("hold_req_ready", rr4, 1'b0);
        end
        rv4 = 1'b0;
        e = q4.pop_front();
        check("bp_sum", sum4, e.sum);
        rdy4 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rdy4 = 1'b0;
        check("release_valid", vv4, 1'b0);
        check("release_busy", busy4, 1'b0);
        check("release_ready", rr4, 1'b1);

        // Reset two cycles into RUN aborts the operation silently.
        send(1'b0, 128'd7, 128'd9, 1'b0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("abort_busy", busy4, 1'b0);
        check("abort_valid", vv4, 1'b0);
        check("abort_sum", sum4, 128'd0);
        q4.delete();
        @(negedge clk);
        reset = 1'b0;
        saw_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (vv4 === 1'b1) saw_valid = 1'b1;
        end
        check("abort_no_valid", saw_valid, 1'b0);
        send(1'b0, 128'h1_0000_0000, 128'hFFFF_FFFF, 1'b0);
        recv(1'b0, 1'b0, lat);

        // Random back-to-back traffic alternating between the two widths.
        for (int i = 0; i < 200; i++) begin
            sel = (i % 2) == 1;
            ra  = {$urandom, $urandom, $urandom, $urandom};
            rb  = {$urandom, $urandom, $urandom, $urandom};
            send(sel, ra, rb, ($urandom_range(0, 1) == 1));
            recv(sel, 1'b1, lat);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
